fpmult_round_stage: RTL
=======================

// Module: fpmult_round_stage
// PURPOSE
//  Final FP-multiply pipeline stage, directly downstream of the execute stage.
//  Consumes normalized sign/exponent/mantissa plus round request GRS.
//  Removes exponent bias, applies rounding, detects overflow/underflow and
//  packs the IEEE-754 product through a 2-stage valid/ready pipeline.
// PARAMETERS
//  EXPONENT  8    exponent field width
//  MANTISSA  23   stored mantissa width (hidden bit excluded)
//  BIAS      127  exponent bias (2^(EXPONENT-1)-1)
// PORTS
//  clk        in   1            single clock, all flops rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  in_valid   in   1            upstream product fields valid
//  in_ready   out  1            stage can accept this cycle
//  Sp         in   1            product sign
//  NormE      in   EXPONENT+1   Ea+Eb+overflow bit, still double-biased
//  NormM      in   MANTISSA     normalized mantissa, hidden bit dropped
//  GRS        in   1            round-up request (1 = increment mantissa)
//  in_nan     in   1            operand exception: result is NaN
//  in_inf     in   1            operand exception: result is infinity
//  in_zero    in   1            operand exception: result is zero
//  out_valid  out  1            P valid
//  out_ready  in   1            downstream accepts P
//  P          out  1+EXPONENT+MANTISSA  packed result {sign,exp,mant}
//  out_ovf    out  1            result overflowed to infinity
//  out_unf    out  1            result flushed to zero
// BEHAVIOUR
//  - Reset (async, rst_n=0): both stage valids, out_valid, P, out_ovf, out_unf = 0.
//    in_ready = 1 once reset releases; in-flight data discarded, no output.
//  - Advance: adv = !out_valid | out_ready; in_ready = adv. Transfer on
//    in_valid & in_ready. Stage regs load only when adv=1; bubbles collapse.
//  - Latency: exactly 2 cycles accept-to-out_valid with out_ready held high;
//    throughput 1/cycle; order preserved; no result dropped or duplicated.
//  - S1: Mr = {1'b0,NormM} + GRS (MANTISSA+1 bits); carry c = Mr[MANTISSA].
//    R = NormE + c - BIAS, signed, EXPONENT+2 bits. Register Sp, Mr, c, R, flags.
//  - S2 priority: in_nan -> P = {0,all-ones,1,0...} (quiet NaN, 0x7FC00000 for 32b);
//    in_inf -> {Sp,all-ones,0}; in_zero -> {Sp,0,0};
//    R >= 2^EXPONENT-1 -> {Sp,all-ones,0}, out_ovf=1;
//    R <= 0 -> {Sp,0,0}, out_unf=1 (no denormals);
//    else {Sp,R[EXPONENT-1:0], c ? 0 : Mr[MANTISSA-1:0]}.
//  - out_ovf/out_unf qualify with out_valid; 0 for exception-input results.
//  - Simultaneous accept and output handshake in one cycle is legal and required.
// CONFIGURATION
//  FPMULT_STICKY_FLAGS_EN defined: adds ports flags_clr (in,1) and
//  sticky_flags (out,2 = {ovf,unf}); each output handshake ORs its flags in;
//  flags_clr=1 clears, and a same-cycle set wins over clear. Reset value 0.
//  Undefined: those ports and the register do not exist; datapath identical.
// STRUCTURE
//  Shared defines file: EXPONENT, MANTISSA, BIAS, ACTUAL_MANTISSA, QNAN constant.
//  One sub-module: fpmult_pipe_ctrl (valid/ready advance logic per stage).
//  Rounding and pack logic stays inline in this module.
// TESTING
//  1) Sp=0,NormE=255,NormM=0x100000,GRS=0 -> P=0x40100000 two cycles later.
//  2) NormE=254,NormM=0x7FFFFF,GRS=1 -> carry, P=0x40000000, out_ovf=0.
//  3) NormE=400 -> P=0x7F800000,out_ovf=1; Sp=1,NormE=100 -> P=0x80000000,out_unf=1.
//  4) in_nan=1 with in_inf=1 -> P=0x7FC00000; in_zero,Sp=1 -> P=0x80000000.
//  5) 4 back-to-back inputs, out_ready low 3 cycles -> in_ready drops when full,
//     all 4 results emerge in order, none lost or repeated.
//  6) rst_n low mid-stream with 2 in flight -> out_valid=0 at once, nothing
//     emitted after release; sticky_flags (macro on) read 0.

Source files
------------

// File: rtl/fpmult_round_stage_pkg.sv
// ----------------------------------------------------------------------------
// fpmult_round_stage_pkg
//   Shared FP-multiply format constants for the round/pack stage and anything
//   else that needs the single-precision field layout.
//   EXPONENT        exponent field width
//   MANTISSA        stored mantissa width (hidden bit excluded)
//   BIAS            exponent bias
//   ACTUAL_MANTISSA mantissa width including the hidden bit
//   QNAN            canonical quiet NaN for the default 32-bit format
// ----------------------------------------------------------------------------
package fpmult_round_stage_pkg;

   localparam int EXPONENT        = 8;
   localparam int MANTISSA        = 23;
   localparam int BIAS            = (1 << (EXPONENT - 1)) - 1;
   localparam int ACTUAL_MANTISSA = MANTISSA + 1;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

endpackage

// File: rtl/fpmult_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// fpmult_pipe_ctrl
//   Valid bit and load enable for one stage of the round/pack pipeline. All
//   stages share one advance signal, so a stalled output freezes the whole
//   pipe and the stage data never needs a skid buffer.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   up_vld      valid of the data presented to this stage
//   adv         pipeline advance (output empty or being taken)
//   vld         this stage holds valid data
//   load        enable for this stage's data registers
// ----------------------------------------------------------------------------
module fpmult_pipe_ctrl (
   input  logic clk,
   input  logic rst_n,
   input  logic up_vld,
   input  logic adv,
   output logic vld,
   output logic load
);

   // Only capture real data; a bubble just clears the valid bit.
   assign load = adv & up_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld <= 1'b0;
      else if (adv) vld <= up_vld;
   end

endmodule

// File: rtl/fpmult_round_stage.sv
// ----------------------------------------------------------------------------
// fpmult_round_stage
//   Final FP-multiply stage: removes the second exponent bias, applies the
//   round increment, detects overflow/underflow and packs the IEEE-754 product
//   through a two-stage valid/ready pipeline (S1 round, S2 pack).
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = pipeline advance)
//   Sp, NormE, NormM, GRS product sign, double-biased exponent, normalized
//                         mantissa (hidden bit dropped), round-up request
//   in_nan/in_inf/in_zero operand exceptions, priority nan > inf > zero
//   out_valid / out_ready downstream handshake
//   P                     packed {sign, exponent, mantissa}
//   out_ovf / out_unf     result saturated to infinity / flushed to zero
// Configuration
//   FPMULT_STICKY_FLAGS_EN adds flags_clr (in) and sticky_flags[1:0] = {ovf,unf}
//   accumulated over output handshakes; a same-cycle set beats the clear.
// ----------------------------------------------------------------------------
module fpmult_round_stage #(
   parameter int EXPONENT = fpmult_round_stage_pkg::EXPONENT,
   parameter int MANTISSA = fpmult_round_stage_pkg::MANTISSA,
   parameter int BIAS     = fpmult_round_stage_pkg::BIAS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         Sp,
   input  logic [EXPONENT:0]            NormE,
   input  logic [MANTISSA-1:0]          NormM,
   input  logic                         GRS,
   input  logic                         in_nan,
   input  logic                         in_inf,
   input  logic                         in_zero,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXPONENT+MANTISSA:0]   P,
   output logic                         out_ovf,
   output logic                         out_unf
`ifdef FPMULT_STICKY_FLAGS_EN
   ,
   input  logic                         flags_clr,
   output logic [1:0]                   sticky_flags
`endif
);

   import fpmult_round_stage_pkg::*;

   localparam int W          = 1 + EXPONENT + MANTISSA;
   localparam int NUM_STAGES = 2;
   localparam logic [EXPONENT+1:0]        BIAS_X = (EXPONENT+2)'(BIAS);
   localparam logic signed [EXPONENT+1:0] R_MAX  = (EXPONENT+2)'((1 << EXPONENT) - 1);
   localparam logic [W-1:0] QNAN_P = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};

   // Rounded mantissa is kept as carry + low bits: the carry bit is the
   // top bit of Mr and doubles as the exponent increment.
   typedef struct packed {
      logic                sp;
      logic                c;
      logic [MANTISSA-1:0] m;
      logic [EXPONENT+1:0] r;     // unbiased exponent, two's complement
      logic                nan;
      logic                inf;
      logic                zero;
   } s1_t;

   logic [NUM_STAGES:0]   vld_pipe;
   logic [NUM_STAGES-1:0] ld;
   logic                  adv;
   s1_t                   s1_d, s1_q;
   logic [W-1:0]          p_d;
   logic                  ovf_d, unf_d;

   assign adv         = ~vld_pipe[NUM_STAGES] | out_ready;
   assign in_ready    = adv;
   assign out_valid   = vld_pipe[NUM_STAGES];
   assign vld_pipe[0] = in_valid;

   fpmult_pipe_ctrl u_ctrl [NUM_STAGES-1:0] (
      .clk    (clk),
      .rst_n  (rst_n),
      .up_vld (vld_pipe[NUM_STAGES-1:0]),
      .adv    (adv),
      .vld    (vld_pipe[NUM_STAGES:1]),
      .load   (ld)
   );

   // ---------------- S1: round and unbias ----------------
   always_comb begin : s1_round
      logic [MANTISSA:0] mr;
      mr        = {1'b0, NormM} + (MANTISSA+1)'(GRS);
      s1_d.sp   = Sp;
      s1_d.c    = mr[MANTISSA];
      s1_d.m    = mr[MANTISSA-1:0];
      s1_d.r    = {1'b0, NormE} + (EXPONENT+2)'(mr[MANTISSA]) - BIAS_X;
      s1_d.nan  = in_nan;
      s1_d.inf  = in_inf;
      s1_d.zero = in_zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     s1_q <= '0;
      else if (ld[0]) s1_q <= s1_d;
   end

   // ---------------- S2: range check and pack ----------------
   always_comb begin : s2_pack
      p_d   = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (s1_q.nan) begin
         p_d = QNAN_P;
      end else if (s1_q.inf) begin
         p_d = {s1_q.sp, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      end else if (s1_q.zero) begin
         p_d = {s1_q.sp, {(W-1){1'b0}}};
      end else if ($signed(s1_q.r) >= R_MAX) begin
         p_d   = {s1_q.sp, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
         ovf_d = 1'b1;
      end else if (s1_q.r[EXPONENT+1] || (s1_q.r == '0)) begin
         // no denormal support: anything at or below exponent 0 flushes
         p_d   = {s1_q.sp, {(W-1){1'b0}}};
         unf_d = 1'b1;
      end else begin
         p_d = {s1_q.sp, s1_q.r[EXPONENT-1:0], s1_q.c ? {MANTISSA{1'b0}} : s1_q.m};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         P       <= '0;
         out_ovf <= 1'b0;
         out_unf <= 1'b0;
      end else if (ld[1]) begin
         P       <= p_d;
         out_ovf <= ovf_d;
         out_unf <= unf_d;
      end
   end

`ifdef FPMULT_STICKY_FLAGS_EN
   logic [1:0] set_flags;

   assign set_flags = (out_valid & out_ready) ? {out_ovf, out_unf} : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_flags <= 2'b00;
      else        sticky_flags <= (flags_clr ? 2'b00 : sticky_flags) | set_flags;
   end
`endif

endmodule
